// File: rtl/div_sequencer.sv
// div_sequencer
// Wraps an external fixed-latency signed divider that has no valid signal
// and no reset. The block:
//   - forwards operands straight to the divider, replacing a zero divisor
//     with 1 so the divider never sees a divide by zero,
//   - carries tag and corner-case flags alongside in a LATENCY-stage pipe,
//   - patches divide-by-zero and INT_MIN/-1 overflow results,
//   - queues results in a DEPTH-entry FIFO with a valid/ready output,
//   - limits outstanding operations to DEPTH with a credit counter, so the
//     FIFO can never overflow even though the pipe cannot stall.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             operand handshake
//   in_a, in_b, in_tag            signed dividend, signed divisor, tag
//   div_sa, div_sb                operands to the external divider
//   div_q, div_r                  divider quotient/remainder, LATENCY later
//   out_valid/out_ready           result handshake
//   out_q, out_r, out_tag, out_dbz  result, tag, divide-by-zero flag
//   busy                          any operation in flight or queued
module div_sequencer #(
  parameter int LATENCY = 5,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      div_sa,
  output logic [31:0]      div_sb,
  input  logic [31:0]      div_q,
  input  logic [31:0]      div_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_q,
  output logic [31:0]      out_r,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic             busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic issue;
  logic pop;
  logic push;
  logic in_dbz;
  logic in_ovf;

  // Sideband pipe: valid bits are control state, the rest is data only.
  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_dbz;
  logic [LATENCY-1:0] pipe_ovf;
  logic [TAG_W-1:0]   pipe_tag [LATENCY];
  logic [31:0]        pipe_a   [LATENCY];

  // Result FIFO storage and control.
  logic [31:0]      fifo_q   [DEPTH];
  logic [31:0]      fifo_r   [DEPTH];
  logic [TAG_W-1:0] fifo_tag [DEPTH];
  logic [DEPTH-1:0] fifo_dbz;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    outstanding;

  logic [31:0] push_q;
  logic [31:0] push_r;
  logic        push_dbz;

  assign in_dbz = (in_b == 32'd0);
  assign in_ovf = (in_a == 32'h8000_0000) && (in_b == 32'hFFFF_FFFF);

  assign div_sa = in_a;
  assign div_sb = in_dbz ? 32'd1 : in_b;

  // Credits cover both the pipe and the FIFO, so a push always finds room.
  assign in_ready  = !rst && (outstanding < DEPTH_C);
  assign issue     = in_valid && in_ready;
  assign out_valid = !rst && (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = pipe_valid[LATENCY-1];
  assign busy      = !rst && (outstanding != '0);

  assign out_q   = fifo_q[rptr];
  assign out_r   = fifo_r[rptr];
  assign out_tag = fifo_tag[rptr];
  assign out_dbz = fifo_dbz[rptr];

  // Select the value to queue; corner cases override the divider output.
  always_comb begin
    push_q   = div_q;
    push_r   = div_r;
    push_dbz = 1'b0;
    if (pipe_dbz[LATENCY-1]) begin
      push_q   = 32'hFFFF_FFFF;
      push_r   = pipe_a[LATENCY-1];
      push_dbz = 1'b1;
    end else if (pipe_ovf[LATENCY-1]) begin
      push_q   = 32'h8000_0000;
      push_r   = 32'd0;
      push_dbz = 1'b0;
    end else begin
      push_q   = div_q;
      push_r   = div_r;
      push_dbz = 1'b0;
    end
  end

  // Control state: pipe valids, FIFO pointers/count and credit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid  <= '0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      outstanding <= '0;
    end else begin
      pipe_valid[0] <= issue;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end

      if (push) begin
        wptr <= (wptr == LAST_PTR) ? '0 : wptr + PW'(1);
      end
      if (pop) begin
        rptr <= (rptr == LAST_PTR) ? '0 : rptr + PW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case ({issue, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Pipe sideband data shifts every cycle; meaningless without its valid bit.
  always_ff @(posedge clk) begin
    pipe_dbz[0] <= in_dbz;
    pipe_ovf[0] <= in_ovf;
    pipe_tag[0] <= in_tag;
    pipe_a[0]   <= in_a;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_dbz[i] <= pipe_dbz[i-1];
      pipe_ovf[i] <= pipe_ovf[i-1];
      pipe_tag[i] <= pipe_tag[i-1];
      pipe_a[i]   <= pipe_a[i-1];
    end
  end

  // FIFO data write; the credit counter guarantees a free slot on push.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wptr]   <= push_q;
      fifo_r[wptr]   <= push_r;
      fifo_tag[wptr] <= pipe_tag[LATENCY-1];
      fifo_dbz[wptr] <= push_dbz;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural divider model.
module tb_div_sequencer;

  localparam int LAT   = 5;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_a = 32'd0;
  logic [31:0]      in_b = 32'd0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      div_sa, div_sb, div_q, div_r;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_q, out_r;
  logic [TAG_W-1:0] out_tag;
  logic             out_dbz;
  logic             busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tracked = 0;
  bit rand_done = 1'b0;

  typedef struct {
    logic [31:0]      q;
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
    logic             dbz;
    int               issue_cyc;
  } exp_t;

  exp_t exp_q[$];

  div_sequencer #(.LATENCY(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_sa(div_sa), .div_sb(div_sb),
    .div_q(div_q), .div_r(div_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_tag(out_tag), .out_dbz(out_dbz),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External divider: fixed latency, no reset; garbage on undefined inputs.
  logic [31:0] dq_pipe [LAT];
  logic [31:0] dr_pipe [LAT];

  function automatic logic [63:0] ext_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
      q = 32'hDEAD_BEEF;
      r = 32'hCAFE_F00D;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
    return {q, r};
  endfunction

  always @(posedge clk) begin
    logic [63:0] res;
    res = ext_div(div_sa, div_sb);
    dq_pipe[0] <= res[63:32];
    dr_pipe[0] <= res[31:0];
    for (int i = 1; i < LAT; i++) begin
      dq_pipe[i] <= dq_pipe[i-1];
      dr_pipe[i] <= dr_pipe[i-1];
    end
  end

  assign div_q = dq_pipe[LAT-1];
  assign div_r = dr_pipe[LAT-1];

  // Reference: what the sequencer must report for an operand pair.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] t, input int c);
    exp_t e;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.tag = t;
    e.issue_cyc = c;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
      e.dbz = 1'b1;
    end else begin
      e.q = 32'(sa / sb);
      e.r = 32'(sa % sb);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks handshake state every cycle and pops the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      tracked = 0;
    end else begin
      logic exp_ov;
      exp_ov = (exp_q.size() != 0) && (cyc >= exp_q[0].issue_cyc + LAT + 1);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (tracked < DEPTH)});
      chk("busy", {31'd0, busy}, {31'd0, (tracked != 0)});
      if (tracked > DEPTH) begin
        chk("outstanding_limit", tracked, DEPTH);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_q", out_q, e.q);
        chk("out_r", out_r, e.r);
        chk("out_tag", {{(32-TAG_W){1'b0}}, out_tag}, {{(32-TAG_W){1'b0}}, e.tag});
        chk("out_dbz", {31'd0, out_dbz}, {31'd0, e.dbz});
        tracked--;
      end
      if (in_valid && in_ready) begin
        chk("div_sb_nonzero", {31'd0, (div_sb == 32'd0)}, 32'd0);
        exp_q.push_back(model(in_a, in_b, in_tag, cyc));
        tracked++;
      end
    end
  end

  // Present one operation and hold until accepted; returns just after the
  // accepting edge with in_valid still high so sends can run back to back.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    bit ok;
    in_a = a;
    in_b = b;
    in_tag = t;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_done", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_b();
    logic [31:0] v;
    v = 32'($urandom_range(1, 20));
    if ($urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  initial begin
    // Reset held for a few cycles.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Directed values; latency is covered by the monitor's out_valid check.
    send(32'd100, 32'd7, 4'd3);
    idle();
    send(-32'sd7, 32'd2, 4'd5);
    idle();
    send(32'd5, 32'd0, 4'd9);
    idle();
    send(32'h8000_0000, 32'hFFFF_FFFF, 4'd12);
    idle();
    wait_empty();

    // Back-pressure: fill credits with the output stalled, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'(1000 + i * 37), 32'(3 + i), TAG_W'(i + 1));
    idle();
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (8) @(negedge clk);
    chk("full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("full_in_ready_hold", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("pre_pop_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("post_pop_in_ready", {31'd0, in_ready}, 32'd1);
    wait_empty();

    // Reset in the middle of three in-flight operations.
    send(32'd50, 32'd5, 4'd1);
    send(32'd60, 32'd6, 4'd2);
    send(32'd70, 32'd0, 4'd3);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("post_rst_no_output", seen, 0);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    end
    @(posedge clk);
    #1;

    // Continuous issue with the output always ready.
    for (int i = 0; i < 20; i++) send($urandom, rand_b(), TAG_W'(i));
    idle();
    wait_empty();

    // Randomised operands with random gaps and random back-pressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [31:0] a, b;
          int k;
          a = $urandom;
          b = $urandom;
          k = $urandom_range(0, 9);
          if (k == 0) b = 32'd0;
          else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          else if (k == 2) begin a = 32'h8000_0000; b = rand_b(); end
          else if (k == 3) b = rand_b();
          send(a, b, TAG_W'($urandom));
          if ($urandom_range(0, 2) == 0) begin
            idle();
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_empty();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
